// File: rtl/time_entry_ctrl_if.sv
// Keypad strobes, timer feedback and timer preset/control lines for time_entry_ctrl.
// The err line exists only when TIME_ENTRY_VALIDATE_EN is defined.
interface time_entry_ctrl_if;
  logic [3:0] key_in;
  logic       key_valid;
  logic       key_start;
  logic       key_clear;
  logic       finished;
  logic [3:0] min_tens;
  logic [3:0] min_unit;
  logic [3:0] sec_tens;
  logic [3:0] sec_unit;
  logic       load;
  logic       enablen;
  logic       running;
  logic       done;
`ifdef TIME_ENTRY_VALIDATE_EN
  logic       err;

  modport master (
    output key_in, key_valid, key_start, key_clear, finished,
    input  min_tens, min_unit, sec_tens, sec_unit, load, enablen, running, done, err
  );
  modport slave (
    input  key_in, key_valid, key_start, key_clear, finished,
    output min_tens, min_unit, sec_tens, sec_unit, load, enablen, running, done, err
  );
`else
  modport master (
    output key_in, key_valid, key_start, key_clear, finished,
    input  min_tens, min_unit, sec_tens, sec_unit, load, enablen, running, done
  );
  modport slave (
    input  key_in, key_valid, key_start, key_clear, finished,
    output min_tens, min_unit, sec_tens, sec_unit, load, enablen, running, done
  );
`endif
endinterface

// File: rtl/time_entry_ctrl.sv
// Keypad front end for the MM:SS countdown timer: digit entry, load, 1 Hz count strobe, pause/done.
// Optional preset/digit validation with err pulse under TIME_ENTRY_VALIDATE_EN.
module time_entry_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  time_entry_ctrl_if.slave bus
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_MAX = CW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    ENTRY = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   digits_q, digits_d;   // {min_tens, min_unit, sec_tens, sec_unit}
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_q, load_d;
  logic          enablen_q, enablen_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic          key_ok_s;
`ifdef TIME_ENTRY_VALIDATE_EN
  logic          err_q, err_d;
  assign key_ok_s = (bus.key_in <= 4'd9);
`else
  assign key_ok_s = 1'b1;
`endif

  // Next state, digits and tick count; outputs are derived from the next state so they register with it
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    cnt_d    = cnt_q;
`ifdef TIME_ENTRY_VALIDATE_EN
    err_d    = 1'b0;
`endif
    case (state_q)
      ENTRY: begin
        if (bus.key_clear) begin
          digits_d = 16'h0000;
        end else if (bus.key_start) begin
          if (digits_q == 16'h0000) begin
            state_d = ENTRY;
`ifdef TIME_ENTRY_VALIDATE_EN
          end else if ((digits_q[15:12] > 4'd5) || (digits_q[7:4] > 4'd5)) begin
            err_d = 1'b1;
`endif
          end else begin
            state_d = LOAD;
          end
        end else if (bus.key_valid && key_ok_s) begin
          digits_d = {digits_q[11:0], bus.key_in};
        end else begin
          digits_d = digits_q;
        end
      end
      LOAD: begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: begin
        cnt_d = (cnt_q == TICK_MAX) ? '0 : cnt_q + CW'(1);
        // finished outranks every key in this state
        if (bus.finished) begin
          state_d = DONE;
        end else if (bus.key_clear) begin
          state_d  = ENTRY;
          digits_d = 16'h0000;
        end else if (bus.key_start) begin
          state_d = PAUSE;
        end else begin
          state_d = RUN;
        end
      end
      PAUSE: begin
        if (bus.key_clear) begin
          state_d  = ENTRY;
          digits_d = 16'h0000;
        end else if (bus.key_start) begin
          state_d = RUN;
        end else begin
          state_d = PAUSE;
        end
      end
      DONE: begin
        if (bus.key_clear) begin
          state_d  = ENTRY;
          digits_d = 16'h0000;
        end else if (bus.key_start) begin
          state_d = LOAD;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d  = ENTRY;
        digits_d = 16'h0000;
      end
    endcase
    load_d    = (state_d == LOAD);
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
    enablen_d = !((state_d == RUN) && (cnt_d == TICK_MAX));
  end

  // State, preset and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ENTRY;
      digits_q  <= 16'h0000;
      cnt_q     <= '0;
      load_q    <= 1'b0;
      enablen_q <= 1'b1;
      running_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef TIME_ENTRY_VALIDATE_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      cnt_q     <= cnt_d;
      load_q    <= load_d;
      enablen_q <= enablen_d;
      running_q <= running_d;
      done_q    <= done_d;
`ifdef TIME_ENTRY_VALIDATE_EN
      err_q     <= err_d;
`endif
    end
  end

  assign bus.min_tens = digits_q[15:12];
  assign bus.min_unit = digits_q[11:8];
  assign bus.sec_tens = digits_q[7:4];
  assign bus.sec_unit = digits_q[3:0];
  assign bus.load     = load_q;
  assign bus.enablen  = enablen_q;
  assign bus.running  = running_q;
  assign bus.done     = done_q;
`ifdef TIME_ENTRY_VALIDATE_EN
  assign bus.err      = err_q;
`endif
endmodule

// File: tb/tb_time_entry_ctrl.sv
// Scoreboard bench for time_entry_ctrl: directed plan sequences plus random strobes,
// expected outputs from a queue-based reference model, compared by a separate monitor.
module tb_time_entry_ctrl;
  localparam int TD = 4;
  localparam int M_ENTRY = 0, M_LOAD = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

  typedef struct packed {
    logic [15:0] digits;
    logic        load;
    logic        enablen;
    logic        running;
    logic        done;
    logic        err;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  time_entry_ctrl_if bus();
  time_entry_ctrl #(.TICK_DIV(TD)) dut (.clk(clk), .rst(rst), .bus(bus));

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // reference model: digits as a 4-entry FIFO (front = min_tens), phase = RUN-cycle position mod TD
  int m_state = M_ENTRY;
  int m_dig[$] = '{0, 0, 0, 0};
  int m_phase = 0;

  task automatic step(input logic r, input logic [3:0] k, input logic v, input logic s,
                      input logic c, input logic f);
    obs_t e;
    int   ns;
    bit   kok, bad, e_err;
    @(negedge clk);
    rst = r; bus.key_in = k; bus.key_valid = v; bus.key_start = s;
    bus.key_clear = c; bus.finished = f;
    ns = m_state; e_err = 1'b0;
`ifdef TIME_ENTRY_VALIDATE_EN
    kok = (k <= 4'd9);
    bad = (m_dig[0] > 5) || (m_dig[2] > 5);
`else
    kok = 1'b1;
    bad = 1'b0;
`endif
    if (r) begin
      ns = M_ENTRY; m_dig = '{0, 0, 0, 0}; m_phase = 0;
    end else begin
      case (m_state)
        M_ENTRY:
          if (c) m_dig = '{0, 0, 0, 0};
          else if (s) begin
            if (m_dig[0] + m_dig[1] + m_dig[2] + m_dig[3] == 0) ns = M_ENTRY;
            else if (bad) e_err = 1'b1;
            else ns = M_LOAD;
          end else if (v && kok) begin
            m_dig.push_back(int'(k));
            void'(m_dig.pop_front());
          end
        M_LOAD: begin ns = M_RUN; m_phase = 0; end
        M_RUN: begin
          m_phase = (m_phase + 1) % TD;
          if (f) ns = M_DONE;
          else if (c) begin ns = M_ENTRY; m_dig = '{0, 0, 0, 0}; end
          else if (s) ns = M_PAUSE;
        end
        M_PAUSE:
          if (c) begin ns = M_ENTRY; m_dig = '{0, 0, 0, 0}; end
          else if (s) ns = M_RUN;
        default:
          if (c) begin ns = M_ENTRY; m_dig = '{0, 0, 0, 0}; end
          else if (s) ns = M_LOAD;
      endcase
    end
    m_state = ns;
    e.digits  = {4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]), 4'(m_dig[3])};
    e.load    = (ns == M_LOAD);
    e.running = (ns == M_RUN);
    e.done    = (ns == M_DONE);
    e.enablen = !((ns == M_RUN) && (m_phase == TD - 1));
    e.err     = e_err;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic key(input logic [3:0] k);
    step(1'b0, k, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start();
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic clear();
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // monitor: every cycle the DUT presents a fresh registered output vector
  always begin
    obs_t e, a;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.digits  = {bus.min_tens, bus.min_unit, bus.sec_tens, bus.sec_unit};
      a.load    = bus.load;
      a.enablen = bus.enablen;
      a.running = bus.running;
      a.done    = bus.done;
`ifdef TIME_ENTRY_VALIDATE_EN
      a.err     = bus.err;
`else
      a.err     = 1'b0;
`endif
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL outputs cycle %0d: got digits=%h load=%b enablen=%b running=%b done=%b err=%b, expected digits=%h load=%b enablen=%b running=%b done=%b err=%b",
                 cyc, a.digits, a.load, a.enablen, a.running, a.done, a.err,
                 e.digits, e.load, e.enablen, e.running, e.done, e.err);
      end
    end
  end

  initial begin
    int budget;
    bus.key_in = 4'd0; bus.key_valid = 1'b0; bus.key_start = 1'b0;
    bus.key_clear = 1'b0; bus.finished = 1'b0;
    // reset state
    step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // 1,2,3,4 then start, run through several strobes
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    start();
    idle(13);
    // pause for 10 cycles, resume, then finished together with start
    start(); idle(10); start(); idle(5);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(3);
    start(); idle(3);
    // overflow of digit entry, clear, start on zero preset
    clear();
    key(4'd9); key(4'd8); key(4'd7); key(4'd6); key(4'd5);
    idle(1);
    clear(); start(); idle(2);
    // out-of-range digit and out-of-range preset
    key(4'hA); idle(1); clear();
    key(4'd0); key(4'd0); key(4'd7); key(4'd0);
    start(); idle(3); clear();
    // reset during LOAD, then during RUN
    key(4'd1); start();
    step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    key(4'd2); start(); idle(3);
    step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    // random strobes, including coincident ones
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, 4'($urandom_range(0, 15)),
           $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
    end
    idle(1);
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
